// File: rtl/vga_pkg.sv
// vga_pkg: shared timing-set struct, default 640x480 constants and mode enum
package vga_pkg;

    typedef struct packed {
        logic [15:0] act;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } timing_t;

    typedef enum logic {
        MODE_0 = 1'b0,
        MODE_1 = 1'b1
    } mode_e;

    localparam int H_ACT_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_ACT_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    function automatic timing_t mk_timing(input int a, input int f, input int s, input int b);
        return timing_t'{16'(a), 16'(f), 16'(s), 16'(b)};
    endfunction

    function automatic int tot_of(input timing_t t);
        return int'(t.act) + int'(t.fp) + int'(t.sync) + int'(t.bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis -- position counter, region decode, sync/active flags, wrap
module vga_axis_counter import vga_pkg::*; #(
    parameter int W = 12
) (
    input  logic         clk_25M,
    input  logic         reset,
    input  logic         en,
    input  timing_t      t,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         in_sync,
    output logic         in_act
);
    logic [15:0] c;
    logic [15:0] sync_lo;

    assign c       = 16'(cnt);
    assign sync_lo = t.act + t.fp;
    assign wrap    = c == t.act + t.fp + t.sync + t.bp - 16'd1;
    assign in_sync = c >= sync_lo && c < sync_lo + t.sync;
    assign in_act  = c < t.act;

    // Step through active, front porch, sync, back porch and return to zero after the last position
    always_ff @(posedge clk_25M)
        if (reset) cnt <= '0;
        else if (en) cnt <= wrap ? '0 : cnt + W'(1);

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: two-mode VGA sync/draw/position generator; VGA_TIMING_FRAME_CNT_EN adds a 16-bit frameCnt output
module vga_timing_gen import vga_pkg::*; #(
    parameter int H_ACT_0  = H_ACT_DEF,
    parameter int H_FP_0   = H_FP_DEF,
    parameter int H_SYNC_0 = H_SYNC_DEF,
    parameter int H_BP_0   = H_BP_DEF,
    parameter int V_ACT_0  = V_ACT_DEF,
    parameter int V_FP_0   = V_FP_DEF,
    parameter int V_SYNC_0 = V_SYNC_DEF,
    parameter int V_BP_0   = V_BP_DEF,
    parameter int H_ACT_1  = H_ACT_DEF,
    parameter int H_FP_1   = H_FP_DEF,
    parameter int H_SYNC_1 = H_SYNC_DEF,
    parameter int H_BP_1   = H_BP_DEF,
    parameter int V_ACT_1  = V_ACT_DEF,
    parameter int V_FP_1   = V_FP_DEF,
    parameter int V_SYNC_1 = V_SYNC_DEF,
    parameter int V_BP_1   = V_BP_DEF,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int POS_W    = 12
) (
    input  logic             clk_25M,
    input  logic             reset,
    input  logic             pixEn,
    input  logic             modeSel,
    output logic             hSync,
    output logic             vSync,
    output logic             draw,
    output logic [POS_W-1:0] hPos,
    output logic [POS_W-1:0] vPos,
    output logic             lineStart,
    output logic             frameStart,
    output logic             modeCur
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frameCnt
`endif
);
    localparam timing_t H0   = mk_timing(H_ACT_0, H_FP_0, H_SYNC_0, H_BP_0);
    localparam timing_t V0   = mk_timing(V_ACT_0, V_FP_0, V_SYNC_0, V_BP_0);
    localparam timing_t H1   = mk_timing(H_ACT_1, H_FP_1, H_SYNC_1, H_BP_1);
    localparam timing_t V1   = mk_timing(V_ACT_1, V_FP_1, V_SYNC_1, V_BP_1);
    localparam logic    HS_A = 1'(HS_POL);
    localparam logic    VS_A = 1'(VS_POL);

    if (POS_W > 16 || tot_of(H0) >= (1 << POS_W) || tot_of(V0) >= (1 << POS_W) ||
        tot_of(H1) >= (1 << POS_W) || tot_of(V1) >= (1 << POS_W)) begin : g_fit
        $error("vga_timing_gen: timing totals do not fit in POS_W bits");
    end

    mode_e            mode_q;
    timing_t          ht;
    timing_t          vt;
    logic [POS_W-1:0] h_cnt;
    logic [POS_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_sync_on;
    logic             v_sync_on;
    logic             h_act;
    logic             v_act;
    logic             frame_wrap;

    assign ht         = mode_q == MODE_1 ? H1 : H0;
    assign vt         = mode_q == MODE_1 ? V1 : V0;
    assign frame_wrap = pixEn & h_wrap & v_wrap;
    assign modeCur    = mode_q;

    vga_axis_counter #(.W(POS_W)) u_h (
        .clk_25M (clk_25M),
        .reset   (reset),
        .en      (pixEn),
        .t       (ht),
        .cnt     (h_cnt),
        .wrap    (h_wrap),
        .in_sync (h_sync_on),
        .in_act  (h_act)
    );

    vga_axis_counter #(.W(POS_W)) u_v (
        .clk_25M (clk_25M),
        .reset   (reset),
        .en      (pixEn & h_wrap),
        .t       (vt),
        .cnt     (v_cnt),
        .wrap    (v_wrap),
        .in_sync (v_sync_on),
        .in_act  (v_act)
    );

    // Register the decode of the pixel being consumed; the mode only changes as a frame wraps
    always_ff @(posedge clk_25M) begin
        if (reset) begin
            mode_q     <= MODE_0;
            hSync      <= ~HS_A;
            vSync      <= ~VS_A;
            draw       <= 1'b0;
            hPos       <= '0;
            vPos       <= '0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            lineStart  <= pixEn && h_cnt == '0;
            frameStart <= pixEn && h_cnt == '0 && v_cnt == '0;
            if (pixEn) begin
                hSync <= h_sync_on ? HS_A : ~HS_A;
                vSync <= v_sync_on ? VS_A : ~VS_A;
                draw  <= h_act & v_act;
                hPos  <= h_act & v_act ? h_cnt : '0;
                vPos  <= h_act & v_act ? v_cnt : '0;
            end
            if (frame_wrap) mode_q <= mode_e'(modeSel);
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Count completed frames, rolling over naturally at 16 bits
    always_ff @(posedge clk_25M)
        if (reset) frameCnt <= '0;
        else if (frame_wrap) frameCnt <= frameCnt + 16'd1;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random-stimulus scoreboard bench against a linear-pixel-index reference model
module tb_vga_timing_gen;

    localparam int H0A = 8, H0F = 2, H0S = 3, H0B = 1;
    localparam int V0A = 4, V0F = 1, V0S = 1, V0B = 1;
    localparam int H1A = 6, H1F = 1, H1S = 2, H1B = 1;
    localparam int V1A = 3, V1F = 1, V1S = 1, V1B = 2;
    localparam logic HS_A = 1'b0;
    localparam logic VS_A = 1'b1;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        dr;
        logic [11:0] hp;
        logic [11:0] vp;
        logic        ls;
        logic        fs;
        logic        mc;
        logic [15:0] fc;
        logic        tag;
    } exp_t;

    logic        clk_25M = 1'b0;
    logic        reset = 1'b1;
    logic        pixEn = 1'b0;
    logic        modeSel = 1'b0;
    logic        hSync, vSync, draw, lineStart, frameStart, modeCur;
    logic [11:0] hPos, vPos;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frameCnt;
`endif

    exp_t        sb[$];
    exp_t        cur;
    exp_t        e;
    int          m_n = 0;
    logic        m_mode = 1'b0;
    logic [15:0] fc = '0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_draw = 0;
    int          n_line = 0;
    int          n_frame = 0;
    logic [29:0] got;
    logic [29:0] want;

    vga_timing_gen #(
        .H_ACT_0(H0A), .H_FP_0(H0F), .H_SYNC_0(H0S), .H_BP_0(H0B),
        .V_ACT_0(V0A), .V_FP_0(V0F), .V_SYNC_0(V0S), .V_BP_0(V0B),
        .H_ACT_1(H1A), .H_FP_1(H1F), .H_SYNC_1(H1S), .H_BP_1(H1B),
        .V_ACT_1(V1A), .V_FP_1(V1F), .V_SYNC_1(V1S), .V_BP_1(V1B),
        .HS_POL(0), .VS_POL(1), .POS_W(12)
    ) dut (
        .clk_25M    (clk_25M),
        .reset      (reset),
        .pixEn      (pixEn),
        .modeSel    (modeSel),
        .hSync      (hSync),
        .vSync      (vSync),
        .draw       (draw),
        .hPos       (hPos),
        .vPos       (vPos),
        .lineStart  (lineStart),
        .frameStart (frameStart),
        .modeCur    (modeCur)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frameCnt   (frameCnt)
`endif
    );

    always #5 clk_25M = ~clk_25M;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        n_chk++;
        if (a === x) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", n, $time, a, x);
    endtask

    // Reference: a frame is a linear run of pixels; row/column come from division by the line length
    task automatic model(input logic r, input logic pe, input logic ms, input logic tg);
        int ha, hf, hs, ht, va, vf, vs, vt, h, v;
        ha = m_mode ? H1A : H0A;
        hf = m_mode ? H1F : H0F;
        hs = m_mode ? H1S : H0S;
        ht = m_mode ? H1A + H1F + H1S + H1B : H0A + H0F + H0S + H0B;
        va = m_mode ? V1A : V0A;
        vf = m_mode ? V1F : V0F;
        vs = m_mode ? V1S : V0S;
        vt = m_mode ? V1A + V1F + V1S + V1B : V0A + V0F + V0S + V0B;
        if (r) begin
            cur = '0;
            cur.hs = ~HS_A;
            cur.vs = ~VS_A;
            m_n = 0;
            m_mode = 1'b0;
            fc = '0;
        end else begin
            cur.ls = 1'b0;
            cur.fs = 1'b0;
            if (pe) begin
                h = m_n % ht;
                v = m_n / ht;
                cur.hs = (h >= ha + hf && h < ha + hf + hs) ? HS_A : ~HS_A;
                cur.vs = (v >= va + vf && v < va + vf + vs) ? VS_A : ~VS_A;
                cur.dr = h < ha && v < va;
                cur.hp = cur.dr ? 12'(h) : 12'd0;
                cur.vp = cur.dr ? 12'(v) : 12'd0;
                cur.ls = h == 0;
                cur.fs = m_n == 0;
                m_n++;
                if (m_n == ht * vt) begin
                    m_n = 0;
                    m_mode = ms;
                    fc++;
                end
            end
        end
        cur.mc = m_mode;
        cur.fc = fc;
        cur.tag = tg;
        sb.push_back(cur);
    endtask

    task automatic step(input logic r, input logic pe, input logic ms, input logic tg);
        @(negedge clk_25M);
        reset = r;
        pixEn = pe;
        modeSel = ms;
        model(r, pe, ms, tg);
    endtask

    always @(posedge clk_25M) begin
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            got  = {hSync, vSync, draw, hPos, vPos, lineStart, frameStart, modeCur};
            want = {e.hs, e.vs, e.dr, e.hp, e.vp, e.ls, e.fs, e.mc};
            chk("outputs", 32'(got), 32'(want));
`ifdef VGA_TIMING_FRAME_CNT_EN
            chk("frameCnt", 32'(frameCnt), 32'(e.fc));
`endif
            if (e.tag) begin
                n_draw  += int'(draw);
                n_line  += int'(lineStart);
                n_frame += int'(frameStart);
            end
        end
    end

    initial begin
        logic ms;
        ms = 1'b0;
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (196) step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b0, 1'(i % 2 == 0), 1'b1, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 40 == 0) ms = ~ms;
            step(1'($urandom % 600 == 0), 1'($urandom % 4 != 0), ms, 1'b0);
        end
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (150) step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk_25M);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("draw_cycles_2_frames", 32'(n_draw), 32'd64);
        chk("line_starts_2_frames", 32'(n_line), 32'd14);
        chk("frame_starts_2_frames", 32'(n_frame), 32'd2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
